// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshake stalls, a retired-instruction counter and illegal/timeout trapping.
module multicycle_control #(
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4,
  parameter int RET_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         Jump,
  output logic               Branch,
  output logic [1:0]         RegSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic [2:0]         state,
  output logic [RET_W-1:0]   retired,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3'd5);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(3'd6);

  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_JR, C_JAL, C_JALR
  } cls_t;

  state_t            r_state;
  logic [TO_W-1:0]   r_wait;
  logic [RET_W-1:0]  r_retired;
  logic [1:0]        r_cause;

  state_t            w_next;
  logic [TO_W-1:0]   w_wait_nxt;
  logic [1:0]        w_cause_nxt;
  logic              w_retire;
  cls_t              w_cls;
  logic              w_unused_inst;

  function automatic cls_t decode(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = C_ILL;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b101010, 6'b101011,
          6'b000000: c = C_RALU;
          6'b001000: c = C_JR;
          6'b001001: c = C_JALR;
          default:   c = C_ILL;
        endcase
      end
      6'b001000: c = C_ADDI;
      6'b001101: c = C_ORI;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [ALUOP_W-1:0] funct_alu(input logic [5:0] fn);
    logic [ALUOP_W-1:0] a;
    case (fn)
      6'b100000, 6'b100001: a = ALU_ADD;
      6'b100010, 6'b100011: a = ALU_SUB;
      6'b100100:            a = ALU_AND;
      6'b100101:            a = ALU_OR;
      6'b101010:            a = ALU_SLT;
      6'b101011:            a = ALU_SLTU;
      default:              a = ALU_NOP;
    endcase
    return a;
  endfunction

  // Only opcode and funct steer control; register/immediate fields feed the datapath.
  assign w_unused_inst = ^inst[25:6];
  assign w_cls         = decode(inst[31:26], inst[5:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
      r_cause   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      r_cause <= w_cause_nxt;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wait_nxt  = '0;
    w_cause_nxt = r_cause;
    w_retire    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegDst      = 2'd0;
    Jump        = 2'd0;
    Branch      = 1'b0;
    RegSrc      = 2'd0;
    ALUOp       = ALU_NOP;
    ALUSrc      = 1'b0;
    RegWrite    = 1'b0;

    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUOp   = ALU_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        // A late mem_ready on the final wait cycle still completes the fetch.
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end

      S_DECODE: begin
        if (w_cls == C_ILL) begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end else begin
          w_next = S_EXEC;
        end
      end

      S_EXEC: begin
        case (w_cls)
          C_RALU: begin
            ALUOp  = funct_alu(inst[5:0]);
            w_next = S_WB;
          end
          C_ADDI: begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_ADD;
            w_next = S_WB;
          end
          C_ORI: begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_OR;
            w_next = S_WB;
          end
          C_LW, C_SW: begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_ADD;
            w_next = S_MEM;
          end
          C_BEQ: begin
            ALUOp       = ALU_SUB;
            Branch      = 1'b1;
            PCWriteCond = 1'b1;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
          end
          C_J, C_JR: begin
            Jump     = (w_cls == C_J) ? 2'd1 : 2'd2;
            PCWrite  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          C_JAL, C_JALR: begin
            Jump     = (w_cls == C_JAL) ? 2'd1 : 2'd2;
            RegDst   = (w_cls == C_JAL) ? 2'd2 : 2'd1;
            PCWrite  = 1'b1;
            RegWrite = 1'b1;
            RegSrc   = 2'd2;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          default: begin
            w_next      = S_TRAP;
            w_cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        ALUOp    = ALU_ADD;
        MemRead  = (w_cls == C_LW);
        MemWrite = (w_cls != C_LW);
        if (mem_ready) begin
          if (w_cls == C_LW) begin
            w_next = S_WB;
          end else begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (w_cls == C_RALU) ? 2'd1 : 2'd0;
        RegSrc   = (w_cls == C_LW) ? 2'd1 : 2'd0;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end

      S_TRAP: w_next = S_TRAP;

      default: w_next = S_FETCH;
    endcase

    // Reset forces FETCH, whose strobes would otherwise start a memory read.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegDst      = 2'd0;
      Jump        = 2'd0;
      Branch      = 1'b0;
      RegSrc      = 2'd0;
      ALUOp       = ALU_NOP;
      ALUSrc      = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign state      = r_state;
  assign retired    = r_retired;
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: hand-computed state sequences and control words.
module tb_multicycle_control;

  localparam logic [2:0] A_NOP = 3'd0, A_ADD = 3'd1, A_SUB = 3'd2, A_SLTU = 3'd6;

  localparam logic [31:0] I_ADDI = 32'h2008_0005;
  localparam logic [31:0] I_LW   = 32'h8C09_0004;
  localparam logic [31:0] I_SW   = 32'hAC09_0008;
  localparam logic [31:0] I_BEQ  = 32'h1109_0003;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_SLTU = 32'h0109_502B;
  localparam logic [31:0] I_JALR = 32'h0100_F809;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, Branch, ALUSrc, RegWrite;
  logic [1:0]  RegDst, Jump, RegSrc, trap_cause;
  logic [2:0]  ALUOp, state;
  logic [31:0] retired;
  logic        trap;
  logic [16:0] ctl;

  int n_total = 0;
  int n_pass  = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst), .Jump(Jump),
    .Branch(Branch), .RegSrc(RegSrc), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .state(state), .retired(retired), .trap(trap),
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  assign ctl = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegDst, Jump,
                Branch, RegSrc, ALUOp, ALUSrc, RegWrite};

  function automatic logic [16:0] mk(input logic pcw, input logic pcwc, input logic irw,
                                     input logic mr, input logic mw, input logic [1:0] rd,
                                     input logic [1:0] j, input logic br, input logic [1:0] rs,
                                     input logic [2:0] alu, input logic as, input logic rw);
    return {pcw, pcwc, irw, mr, mw, rd, j, br, rs, alu, as, rw};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic st(input string tag, input logic [2:0] exp);
    #1;
    check(tag, {29'd0, state}, {29'd0, exp});
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state: FETCH, but every strobe suppressed while rst is high
    @(posedge clk); @(posedge clk); #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_ctl", {15'd0, ctl}, 32'd0);
    check("rst_ret", retired, 32'd0);
    check("rst_trap", {30'd0, trap_cause, trap} , 32'd0);
    rst = 1'b0;

    // Back-to-back program with memory always ready
    mem_ready = 1'b1;
    inst = I_ADDI;
    st("addi_f", 3'd0); check("addi_f_ctl", {15'd0, ctl}, {15'd0, mk(1,0,1,1,0,0,0,0,0,A_ADD,0,0)});
    tk(); st("addi_d", 3'd1);
    tk(); st("addi_e", 3'd2); check("addi_e_ctl", {15'd0, ctl}, {15'd0, mk(0,0,0,0,0,0,0,0,0,A_ADD,1,0)});
    tk(); st("addi_w", 3'd4); check("addi_w_ctl", {15'd0, ctl}, {15'd0, mk(0,0,0,0,0,0,0,0,0,A_NOP,0,1)});
    tk(); inst = I_LW;
    st("lw_f", 3'd0); tk(); st("lw_d", 3'd1); tk(); st("lw_e", 3'd2);
    tk(); st("lw_m", 3'd3); check("lw_m_ctl", {15'd0, ctl}, {15'd0, mk(0,0,0,1,0,0,0,0,0,A_ADD,0,0)});
    tk(); st("lw_w", 3'd4); check("lw_w_ctl", {15'd0, ctl}, {15'd0, mk(0,0,0,0,0,0,0,0,1,A_NOP,0,1)});
    tk(); inst = I_SW;
    st("sw_f", 3'd0); tk(); st("sw_d", 3'd1); tk(); st("sw_e", 3'd2);
    tk(); st("sw_m", 3'd3); check("sw_m_ctl", {15'd0, ctl}, {15'd0, mk(0,0,0,0,1,0,0,0,0,A_ADD,0,0)});
    tk(); inst = I_BEQ;
    st("beq_f", 3'd0); tk(); st("beq_d", 3'd1);
    tk(); st("beq_e", 3'd2); check("beq_e_ctl", {15'd0, ctl}, {15'd0, mk(0,1,0,0,0,0,0,1,0,A_SUB,0,0)});
    tk(); inst = I_JAL;
    st("jal_f", 3'd0); tk(); st("jal_d", 3'd1);
    tk(); st("jal_e", 3'd2); check("jal_e_ctl", {15'd0, ctl}, {15'd0, mk(1,0,0,0,0,2,1,0,2,A_NOP,0,1)});
    tk(); st("prog_end", 3'd0);
    check("prog_ret", retired, 32'd5);

    // lw with three stalled MEM cycles
    inst = I_LW;
    tk(); st("lws_d", 3'd1); tk(); st("lws_e", 3'd2); tk();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st("lws_m_wait", 3'd3);
      check("lws_memread", {31'd0, MemRead}, 32'd1);
      check("lws_ret_hold", retired, 32'd5);
      tk();
    end
    mem_ready = 1'b1;
    st("lws_m_done", 3'd3); check("lws_memread4", {31'd0, MemRead}, 32'd1);
    tk(); st("lws_w", 3'd4); check("lws_ret_wb", retired, 32'd5);
    tk(); st("lws_f", 3'd0); check("lws_ret", retired, 32'd6);

    // sw stalled in MEM, asynchronous reset mid-cycle
    inst = I_SW;
    tk(); st("swr_d", 3'd1); tk(); st("swr_e", 3'd2); tk();
    mem_ready = 1'b0;
    st("swr_m", 3'd3); check("swr_mw", {31'd0, MemWrite}, 32'd1);
    #2; rst = 1'b1; #1;
    check("swr_rst_state", {29'd0, state}, 32'd0);
    check("swr_rst_mw", {31'd0, MemWrite}, 32'd0);
    check("swr_rst_ret", retired, 32'd0);
    tk(); rst = 1'b0;

    // FETCH timeout: 15 waiting cycles then TRAP cause 2
    for (int i = 0; i < 15; i++) begin
      st("to_f", 3'd0);
      check("to_notrap", {31'd0, trap}, 32'd0);
      tk();
    end
    st("to_trap", 3'd7);
    check("to_flag", {30'd0, trap_cause, trap}, {30'd0, 2'd2, 1'b1});
    check("to_ctl", {15'd0, ctl}, 32'd0);
    mem_ready = 1'b1;
    tk(); st("to_hold", 3'd7);
    rst = 1'b1; #1;
    check("to_rst", {29'd0, trap_cause, trap, 1'b0}, 32'd0);
    tk(); rst = 1'b0;

    // mem_ready on the 15th FETCH cycle wins over the timeout
    mem_ready = 1'b0;
    inst = I_SLTU;
    for (int i = 0; i < 14; i++) begin
      st("late_f", 3'd0);
      tk();
    end
    mem_ready = 1'b1;
    st("late_f15", 3'd0); check("late_irw", {31'd0, IRWrite}, 32'd1);
    tk(); st("late_d", 3'd1); check("late_notrap", {31'd0, trap}, 32'd0);
    tk(); st("sltu_e", 3'd2); check("sltu_e_ctl", {15'd0, ctl}, {15'd0, mk(0,0,0,0,0,0,0,0,0,A_SLTU,0,0)});
    tk(); st("sltu_w", 3'd4); check("sltu_w_ctl", {15'd0, ctl}, {15'd0, mk(0,0,0,0,0,1,0,0,0,A_NOP,0,1)});
    tk(); inst = I_JALR;
    st("jalr_f", 3'd0); tk(); st("jalr_d", 3'd1);
    tk(); st("jalr_e", 3'd2); check("jalr_e_ctl", {15'd0, ctl}, {15'd0, mk(1,0,0,0,0,1,2,0,2,A_NOP,0,1)});
    tk(); st("jalr_end", 3'd0); check("jalr_ret", retired, 32'd2);

    // Illegal opcode traps after DECODE and stays there with strobes off
    inst = I_ILL;
    tk(); st("ill_d", 3'd1);
    tk(); st("ill_trap", 3'd7);
    check("ill_flag", {30'd0, trap_cause, trap}, {30'd0, 2'd1, 1'b1});
    check("ill_ctl", {15'd0, ctl}, 32'd0);
    mem_ready = 1'b0;
    tk(); tk(); st("ill_hold", 3'd7); check("ill_ctl_hold", {15'd0, ctl}, 32'd0);
    check("ill_ret", retired, 32'd2);
    rst = 1'b1; #1;
    check("ill_rst", {29'd0, state}, 32'd0);
    check("ill_rst_trap", {30'd0, trap_cause, trap} , 32'd0);
    tk(); rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS central control unit. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and stalls on a memory ready handshake. It also counts retired instructions and traps on illegal opcodes or memory timeouts. It sits between the instruction register and the multi-cycle datapath: PC, RF, ALU and unified memory.

Parameters:
ALUOP_W, 3, width of ALUOp; encodings come from ctrl_encode_def.v (`ALU_ADD/SUB/AND/OR/SLT/SLTU/NOP).
TIMEOUT, 15, max cycles to wait for mem_ready in FETCH or MEM before trapping (1..2^TO_W-1).
TO_W, 4, width of the wait counter.
RET_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
inst  in  32  instruction register contents; valid from DECODE onward.
mem_ready  in  1  memory completes the current access this cycle.
PCWrite  out  1  write PC (PC+4 in FETCH, target in EXEC jumps).
PCWriteCond  out  1  write branch target if ALU zero.
IRWrite  out  1  latch fetched instruction.
MemRead  out  1  memory read request (FETCH, lw MEM).
MemWrite  out  1  memory write request (sw MEM).
RegDst  out  2  0 rt, 1 rd, 2 $31.
Jump  out  2  0 none, 1 imm26, 2 register.
Branch  out  1  beq in EXEC.
RegSrc  out  2  0 ALU, 1 memory data register, 2 PC (already PC+4).
ALUOp  out  ALUOP_W  ALU operation.
ALUSrc  out  1  0 RF rd2, 1 ext imm.
RegWrite  out  1  RF write strobe.
state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP.
retired  out  RET_W  count of completed instructions; wraps modulo 2^RET_W.
trap  out  1  sticky, high in TRAP.
trap_cause  out  2  0 none, 1 illegal instruction, 2 memory timeout.

Behaviour:
- Reset (async, any state, mid-access included): state=FETCH, wait counter=0, retired=0, trap=0, trap_cause=0. All strobe outputs are 0 while rst is high.
- Outputs are combinational from state, inst and mem_ready. Any strobe not listed for a state is 0.
- FETCH:
  - MemRead=1, ALUOp=`ALU_ADD. IRWrite and PCWrite equal mem_ready.
  - If mem_ready, go to DECODE and clear the wait counter. Otherwise the counter increments.
- DECODE:
  - Legal set: R-type funct add/addu/sub/subu/and/or/slt/sltu/sll-nop/jr/jalr, plus addi, ori, lw, sw, beq, j, jal. Any other opcode or funct goes to TRAP with cause 1.
  - Legal instructions go to EXEC.
- EXEC, by instruction:
  - R-type ALU: ALUSrc=0, ALUOp from funct (addu->ADD, subu->SUB, nop->NOP); next WB.
  - addi/ori: ALUSrc=1, ALUOp ADD/OR; next WB.
  - lw/sw: ALUSrc=1, ALUOp ADD; next MEM.
  - beq: ALUSrc=0, ALUOp SUB, Branch=1, PCWriteCond=1; retire, next FETCH.
  - j: Jump=1, PCWrite=1; retire, next FETCH.
  - jr: Jump=2, PCWrite=1; retire, next FETCH.
  - jal: Jump=1, PCWrite=1, RegWrite=1, RegDst=2, RegSrc=2; retire, next FETCH.
  - jalr: Jump=2, PCWrite=1, RegWrite=1, RegDst=1, RegSrc=2; retire, next FETCH.
- MEM:
  - lw holds MemRead=1; sw holds MemWrite=1; ALUOp ADD; the strobe stays held until mem_ready.
  - On mem_ready: lw goes to WB; sw retires and goes to FETCH.
- WB:
  - RegWrite=1 for one cycle. RegDst=1 for R-type, 0 for addi/ori/lw. RegSrc=1 for lw, else 0.
  - Retire, next FETCH.
- Wait counter: counts consecutive cycles in FETCH/MEM with mem_ready=0. When it reaches TIMEOUT, go to TRAP with cause 2. mem_ready arriving on that same cycle wins: no trap.
- TRAP: all strobes 0, trap=1. Held until reset.
- Retire: retired increments by 1 on the clock edge leaving the final state.
- Latency with mem_ready=1 constantly: R/addi/ori 4 cycles, lw 5, sw 4, beq/j/jr/jal/jalr 3. Each stall cycle adds 1.

Test Plan:
- Reset mid-MEM of sw (MemWrite=1), rst pulsed asynchronously -> state=0, MemWrite=0 immediately, retired=0.
- mem_ready=1 constantly, program addi, lw, sw, beq, jal -> state sequences 0-1-2-4, 0-1-2-3-4, 0-1-2-3, 0-1-2, 0-1-2. retired=5 after 19 cycles. jal shows RegDst=2, RegSrc=2, Jump=1.
- lw with mem_ready low 3 cycles in MEM -> MemRead held 4 cycles, WB on the 5th, retired +1 only after WB.
- mem_ready stuck 0 in FETCH, TIMEOUT=15 -> TRAP after 15 cycles, trap_cause=2. Repeat with mem_ready=1 on cycle 15 -> DECODE, no trap.
- inst opcode 6'b111111 -> TRAP after DECODE, trap_cause=1, all strobes 0 until rst.
- R-type sltu, then jalr -> EXEC ALUOp=`ALU_SLTU, WB RegDst=1. jalr: Jump=2, PCWrite=1, RegWrite=1, RegDst=1.
